// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings and default frame parameters for the
//               UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage
`default_nettype wire

// File: rtl/counter_nbit.sv
`default_nettype none
// ============================================================================
// Module      : counter_nbit
// Description : N-bit up counter with synchronous clear and increment enable.
//               Clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register: clear wins, otherwise step by one when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Double-buffered UART transmitter. The host writes a byte into
//               the holding register (TDR); the state machine moves it into
//               the shift register (TSR) and sends start, data (LSB first)
//               and stop bits on txd. A byte waiting in TDR at the end of a
//               stop cell is started immediately, so frames go back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS             = DEFAULT_DATA_BITS,
    parameter int CLKS_PER_BIT          = DEFAULT_CLKS_PER_BIT,
    parameter int BIT_CELL_COUNTER_BITS = 4,
    parameter int SENT_BIT_COUNTER_BITS = 4
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] TDR_in,
    input  logic                 load_TDRH,
    output logic                 txd,
    output logic                 tdreH,
    output logic                 tx_busyH
);

    localparam logic [BIT_CELL_COUNTER_BITS-1:0] CELL_LAST =
        BIT_CELL_COUNTER_BITS'(CLKS_PER_BIT - 1);
    // The sent-bit counter includes the start cell, so the last data cell
    // ends when it reads DATA_BITS.
    localparam logic [SENT_BIT_COUNTER_BITS-1:0] SENT_LAST =
        SENT_BIT_COUNTER_BITS'(DATA_BITS);

    tx_state_t                        state;
    logic [DATA_BITS-1:0]             tdr;
    logic [DATA_BITS-1:0]             tsr;
    logic [BIT_CELL_COUNTER_BITS-1:0] cell_count;
    logic [SENT_BIT_COUNTER_BITS-1:0] sent_count;

    logic cell_end;
    logic transfer;
    logic cell_clear;
    logic sent_clear;
    logic sent_inc;

    // Cell timing and the TDR->TSR hand-off condition
    always_comb begin
        cell_end   = (cell_count == CELL_LAST);
        transfer   = !tdreH && ((state == ST_IDLE) ||
                                ((state == ST_STOP) && cell_end));
        cell_clear = (state == ST_IDLE) || cell_end;
        sent_clear = (state == ST_IDLE) || ((state == ST_STOP) && cell_end);
        sent_inc   = cell_end && ((state == ST_START) || (state == ST_DATA));
    end

    counter_nbit #(
        .WIDTH (BIT_CELL_COUNTER_BITS)
    ) u_cell_counter (
        .clk   (sysclk),
        .rst_n (rst_n),
        .clear (cell_clear),
        .inc   (1'b1),
        .count (cell_count)
    );

    counter_nbit #(
        .WIDTH (SENT_BIT_COUNTER_BITS)
    ) u_sent_counter (
        .clk   (sysclk),
        .rst_n (rst_n),
        .clear (sent_clear),
        .inc   (sent_inc),
        .count (sent_count)
    );

    // Holding register: accept a write only while empty, refill flag on hand-off
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tdr   <= '0;
            tdreH <= 1'b1;
        end else if (load_TDRH && tdreH) begin
            tdr   <= TDR_in;
            tdreH <= 1'b0;
        end else if (transfer) begin
            tdreH <= 1'b1;
        end
    end

    // Frame sequencer driving registered txd, busy flag and the shift register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tsr      <= '0;
            txd      <= 1'b1;
            tx_busyH <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd      <= 1'b1;
                    tx_busyH <= 1'b0;
                    if (transfer) begin
                        tsr      <= tdr;
                        txd      <= 1'b0;
                        tx_busyH <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (cell_end) begin
                        txd   <= tsr[0];
                        tsr   <= tsr >> 1;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cell_end) begin
                        if (sent_count == SENT_LAST) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            txd <= tsr[0];
                            tsr <= tsr >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cell_end) begin
                        if (transfer) begin
                            tsr   <= tdr;
                            txd   <= 1'b0;
                            state <= ST_START;
                        end else begin
                            tx_busyH <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx (8 data bits, 16 clocks/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] TDR_in;
    logic       load_TDRH;
    logic       txd;
    logic       tdreH;
    logic       tx_busyH;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th cell on the line (start first)
    } vec_t;

    vec_t vecs [7];

    uart_tx dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .TDR_in    (TDR_in),
        .load_TDRH (load_TDRH),
        .txd       (txd),
        .tdreH     (tdreH),
        .tx_busyH  (tx_busyH)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write a byte from idle and step to the first cycle of its start bit
    task automatic start_frame(input logic [7:0] data, input string name);
        TDR_in    = data;
        load_TDRH = 1'b1;
        tick();
        load_TDRH = 1'b0;
        TDR_in    = 8'hE7;
        check({name, " tdre_after_load"}, 32'(tdreH), 32'd0);
        check({name, " txd_before_start"}, 32'(txd), 32'd1);
        tick();
        check({name, " txd_start"}, 32'(txd), 32'd0);
        check({name, " tdre_after_xfer"}, 32'(tdreH), 32'd1);
        check({name, " busy_start"}, 32'(tx_busyH), 32'd1);
    endtask

    // Called on the first cycle of a start bit; checks all ten cells for exact
    // length, optionally writes a next byte on cycle 0 and a rejected byte on cycle 50
    task automatic check_frame(input logic [9:0] exp, input logic [7:0] exp_byte,
                               input bit nv, input logic [7:0] nd,
                               input bit jv, input logic [7:0] jd,
                               input string name);
        int         good;
        int         idx;
        logic [7:0] rx;
        rx = 8'h00;
        for (int b = 0; b < 10; b++) begin
            good = 0;
            for (int c = 0; c < 16; c++) begin
                idx = b * 16 + c;
                if (idx == 0 && nv) begin
                    load_TDRH = 1'b1;
                    TDR_in    = nd;
                end else if (idx == 50 && jv) begin
                    check({name, " tdre_before_overrun"}, 32'(tdreH), 32'd0);
                    load_TDRH = 1'b1;
                    TDR_in    = jd;
                end else begin
                    load_TDRH = 1'b0;
                    TDR_in    = 8'($urandom);
                end
                if (txd === exp[b]) good++;
                if (c == 8 && b >= 1 && b <= 8) rx[b-1] = txd;
                if (idx == 159) check({name, " busy_last_cycle"}, 32'(tx_busyH), 32'd1);
                tick();
            end
            check($sformatf("%s cell%0d", name, b), 32'(good), 32'd16);
        end
        load_TDRH = 1'b0;
        check({name, " rx_byte"}, 32'(rx), 32'(exp_byte));
        if (nv) begin
            check({name, " b2b_txd_start"}, 32'(txd), 32'd0);
            check({name, " b2b_busy"}, 32'(tx_busyH), 32'd1);
            check({name, " b2b_tdre"}, 32'(tdreH), 32'd1);
        end else begin
            check({name, " end_txd"}, 32'(txd), 32'd1);
            check({name, " end_busy"}, 32'(tx_busyH), 32'd0);
            check({name, " end_tdre"}, 32'(tdreH), 32'd1);
        end
    endtask

    initial begin
        int good;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        TDR_in    = 8'h00;
        load_TDRH = 1'b0;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h55, 10'b1_01010101_0};
        vecs[4] = '{8'h80, 10'b1_10000000_0};
        vecs[5] = '{8'h3C, 10'b1_00111100_0};
        vecs[6] = '{8'hC3, 10'b1_11000011_0};

        // Reset state
        tick();
        tick();
        check("reset txd", 32'(txd), 32'd1);
        check("reset tdre", 32'(tdreH), 32'd1);
        check("reset busy", 32'(tx_busyH), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frames from idle, one per table entry
        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].data, $sformatf("vec%0d", i));
            check_frame(vecs[i].frame, vecs[i].data, 1'b0, 8'h00, 1'b0, 8'h00,
                        $sformatf("vec%0d", i));
            tick();
        end

        // Back-to-back: second byte written on the first cycle tdreH is high
        start_frame(8'h3C, "b2b1");
        check_frame(vecs[5].frame, 8'h3C, 1'b1, 8'hC3, 1'b0, 8'h00, "b2b1");
        check_frame(vecs[6].frame, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, "b2b2");
        tick();

        // Overrun: write 0x22 while 0x11 waits in TDR, then 0x33 once accepted
        TDR_in    = 8'h11;
        load_TDRH = 1'b1;
        tick();
        TDR_in    = 8'h22;
        check("ovr tdre_low", 32'(tdreH), 32'd0);
        tick();
        load_TDRH = 1'b0;
        check("ovr txd_start", 32'(txd), 32'd0);
        check("ovr tdre_high", 32'(tdreH), 32'd1);
        // 0x33 queued at cycle 0, 0x44 written mid-frame while full is dropped
        check_frame(10'b1_00010001_0, 8'h11, 1'b1, 8'h33, 1'b1, 8'h44, "ovr1");
        check_frame(10'b1_00110011_0, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, "ovr2");
        tick();

        // Asynchronous reset in the middle of a data bit of 0xFF
        start_frame(8'hFF, "rst");
        for (int i = 0; i < 40; i++) tick();
        check("rst pre txd", 32'(txd), 32'd1);
        check("rst pre busy", 32'(tx_busyH), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst async txd", 32'(txd), 32'd1);
        check("rst async tdre", 32'(tdreH), 32'd1);
        check("rst async busy", 32'(tx_busyH), 32'd0);
        tick();
        rst_n = 1'b1;
        good = 0;
        for (int i = 0; i < 200; i++) begin
            if (txd === 1'b1 && tx_busyH === 1'b0) good++;
            tick();
        end
        check("rst no_spurious_start", 32'(good), 32'd200);

        // Idle stability
        good = 0;
        for (int i = 0; i < 1000; i++) begin
            if (txd === 1'b1 && tdreH === 1'b1 && tx_busyH === 1'b0 &&
                dut.cell_count === 4'd0 && dut.sent_count === 4'd0) good++;
            tick();
        end
        check("idle stable_cycles", 32'(good), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
